// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      PRESS_DB,
      HELD,
      RELEASE_DB
   } state_t;

   // Key legend indexed [row][col]; the code is the hex value of the legend.
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   localparam logic [3:0] COLS_RESET = 4'b1110;

   // Advance the active-low column drive: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
   function automatic logic [3:0] rotate_cols(input logic [3:0] cols);
      return {cols[2:0], cols[3]};
   endfunction

   // Index of the single low bit in a one-hot-low column drive.
   function automatic logic [1:0] col_index(input logic [3:0] cols);
      logic [1:0] idx;
      unique case (cols)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Lowest-index row that reads low; 0 when none is low.
   function automatic logic [1:0] lowest_low(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows; idles high (no key).
module sync_2ff (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   // Shift the raw rows through two flops to settle metastability.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so both stages sample the pre-edge values.
      if (reset) begin
         meta_q <= 4'b1111;
         sync_q <= 4'b1111;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, key decode and
// a two-digit history that feeds the display mux.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);

   logic [3:0] rows_s;

   state_t         state_q,     state_d;
   logic [3:0]     cols_q,      cols_d;
   logic [DW-1:0]  dwell_q,     dwell_d;
   logic [DBW-1:0] db_q,        db_d;
   logic [1:0]     col_idx_q,   col_idx_d;
   logic [1:0]     row_idx_q,   row_idx_d;
   logic [3:0]     key_code_q,  key_code_d;
   logic           key_valid_q, key_valid_d;
   logic [3:0]     digit_new_q, digit_new_d;
   logic [3:0]     digit_old_q, digit_old_d;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rows),
      .q     (rows_s)
   );

   // Next-state logic for the scan/debounce FSM and everything it owns.
   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      state_d     = state_q;
      cols_d      = cols_q;
      dwell_d     = dwell_q;
      db_d        = db_q;
      col_idx_d   = col_idx_q;
      row_idx_d   = row_idx_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      digit_new_d = digit_new_q;
      digit_old_d = digit_old_q;

      unique case (state_q)
         SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (rows_s != 4'b1111) begin
                  col_idx_d = col_index(cols_q);
                  row_idx_d = lowest_low(rows_s);
                  db_d      = '0;
                  state_d   = PRESS_DB;
               end else begin
                  cols_d = rotate_cols(cols_q);
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end

         PRESS_DB: begin
            if (!rows_s[row_idx_q]) begin
               if (db_q == DB_LAST) begin
                  key_valid_d = 1'b1;
                  key_code_d  = KEYMAP[row_idx_q][col_idx_q];
                  digit_old_d = digit_new_q;
                  digit_new_d = KEYMAP[row_idx_q][col_idx_q];
                  db_d        = '0;
                  state_d     = HELD;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end else begin
               // Bounce: abandon this key and continue scanning from the next column.
               db_d    = '0;
               dwell_d = '0;
               cols_d  = rotate_cols(cols_q);
               state_d = SCAN;
            end
         end

         HELD: begin
            if (rows_s[row_idx_q]) begin
               db_d    = '0;
               state_d = RELEASE_DB;
            end
         end

         RELEASE_DB: begin
            if (rows_s[row_idx_q]) begin
               if (db_q == DB_LAST) begin
                  db_d    = '0;
                  dwell_d = '0;
                  cols_d  = rotate_cols(cols_q);
                  state_d = SCAN;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end else begin
               db_d = '0;
            end
         end

         default: begin
            state_d = SCAN;
            cols_d  = COLS_RESET;
            dwell_d = '0;
            db_d    = '0;
         end
      endcase
   end

   // State register with synchronous reset; a reset mid-press simply discards it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SCAN;
         cols_q      <= COLS_RESET;
         dwell_q     <= '0;
         db_q        <= '0;
         col_idx_q   <= '0;
         row_idx_q   <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         digit_new_q <= '0;
         digit_old_q <= '0;
      end else begin
         state_q     <= state_d;
         cols_q      <= cols_d;
         dwell_q     <= dwell_d;
         db_q        <= db_d;
         col_idx_q   <= col_idx_d;
         row_idx_q   <= row_idx_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         digit_new_q <= digit_new_d;
         digit_old_q <= digit_old_d;
      end
   end

   assign cols      = cols_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign digit_new = digit_new_q;
   assign digit_old = digit_old_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives rows from the
// pressed-key matrix and the column drive; a scoreboard holds expected presses.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DB       = 8;
   localparam int LONG_MIN = 40;   // long enough to be accepted from any scan phase
   localparam int SHORT_MAX = 7;   // too short to ever reach DB stable samples
   localparam int GAP      = 30;   // covers release debounce

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       key_valid;
   logic [3:0] digit_new;
   logic [3:0] digit_old;

   logic [3:0][3:0] pressed = '0;  // [row][col]

   typedef struct {
      logic [3:0] code;
      logic [3:0] dnew;
      logic [3:0] dold;
   } exp_t;

   exp_t exp_q[$];
   logic [3:0] hist_new = 4'h0;
   logic [3:0] hist_old = 4'h0;
   int n_cmp = 0;
   int n_err = 0;
   int n_pushed = 0;
   int n_pulses = 0;

   string LEGEND = "123A456B789CE0FD";

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DB)) dut (
      .clk       (clk),
      .reset     (reset),
      .rows      (rows),
      .cols      (cols),
      .key_code  (key_code),
      .key_valid (key_valid),
      .digit_new (digit_new),
      .digit_old (digit_old)
   );

   always #5 clk = ~clk;

   // A row reads low when any pressed key on it sits in a driven (low) column.
   function automatic logic [3:0] keypad_rows(input logic [3:0] c, input logic [3:0][3:0] p);
      logic [3:0] r;
      r = 4'b1111;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (p[i][j] && !c[j]) r[i] = 1'b0;
      return r;
   endfunction

   assign rows = keypad_rows(cols, pressed);

   function automatic logic [3:0] legend_code(input int r, input int c);
      byte ch;
      ch = LEGEND[r*4 + c];
      if (ch >= "0" && ch <= "9") return 4'(ch - "0");
      return 4'(ch - "A" + 10);
   endfunction

   function automatic logic [3:0] col_drive(input int idx);
      logic [3:0] v;
      v = 4'b1111;
      v[idx] = 1'b0;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_key(input logic [3:0] code);
      exp_t e;
      hist_old = hist_new;
      hist_new = code;
      e.code = code;
      e.dnew = hist_new;
      e.dold = hist_old;
      exp_q.push_back(e);
      n_pushed++;
   endtask

   task automatic press(input int r, input int c, input int hold, input bit accept);
      if (accept) expect_key(legend_code(r, c));
      pressed[r][c] = 1'b1;
      cycles(hold);
      pressed[r][c] = 1'b0;
   endtask

   // Scoreboard monitor: every key_valid pulse must match the oldest expected press.
   initial begin
      logic prev_kv;
      exp_t e;
      prev_kv = 1'b0;
      forever begin
         @(negedge clk);
         if (key_valid) begin
            n_pulses++;
            check("pulse_single_cycle", {31'b0, prev_kv}, 32'd0);
            check("pulse_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("key_code", {28'b0, key_code}, {28'b0, e.code});
               check("digit_new", {28'b0, digit_new}, {28'b0, e.dnew});
               check("digit_old", {28'b0, digit_old}, {28'b0, e.dold});
            end
         end
         prev_kv = key_valid;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int start_cols;
      bit moved;

      // Reset state and idle column rotation.
      cycles(3);
      reset = 1'b0;
      check("reset_cols", {28'b0, cols}, 32'hE);
      check("reset_key_valid", {31'b0, key_valid}, 32'd0);
      check("reset_key_code", {28'b0, key_code}, 32'd0);
      check("reset_digit_new", {28'b0, digit_new}, 32'd0);
      check("reset_digit_old", {28'b0, digit_old}, 32'd0);
      for (int k = 0; k < 20; k++) begin
         check($sformatf("idle_rotate_%0d", k), {28'b0, cols}, {28'b0, col_drive((k / SCAN_DIV) % 4)});
         cycles(1);
      end

      // Hold '6' (row1, col2): one pulse, columns frozen on col2 while held.
      expect_key(legend_code(1, 2));
      pressed[1][2] = 1'b1;
      cycles(LONG_MIN);
      for (int k = 0; k < 3; k++) begin
         check("held_cols_frozen", {28'b0, cols}, 32'hB);
         cycles(5);
      end
      pressed[1][2] = 1'b0;
      cycles(GAP);

      // Then 'D' (row3, col3): history becomes D over 6.
      press(3, 3, LONG_MIN, 1'b1);
      cycles(GAP);

      // Bouncing '5': never stable long enough, scan must keep moving.
      for (int k = 0; k < 5; k++) begin
         pressed[1][1] = 1'b1;
         cycles(3);
         pressed[1][1] = 1'b0;
         cycles(1);
      end
      cycles(GAP);
      start_cols = cols;
      moved = 1'b0;
      for (int k = 0; k < 2 * SCAN_DIV && !moved; k++) begin
         cycles(1);
         if (cols != start_cols[3:0]) moved = 1'b1;
      end
      check("scan_resumes_after_bounce", {31'b0, moved}, 32'd1);

      // Long hold of '1' with a release glitch inside the release debounce.
      expect_key(legend_code(0, 0));
      pressed[0][0] = 1'b1;
      cycles(200);
      pressed[0][0] = 1'b0;
      cycles(5);
      pressed[0][0] = 1'b1;
      cycles(2);
      pressed[0][0] = 1'b0;
      cycles(4);
      check("glitch_restarts_release_db", {28'b0, cols}, 32'hE);
      cycles(GAP);

      // Randomized presses: long ones are accepted exactly once, short ones never.
      for (int n = 0; n < 12; n++) begin
         int r, c;
         bit acc;
         r   = $urandom_range(0, 3);
         c   = $urandom_range(0, 3);
         acc = 1'($urandom_range(0, 1));
         press(r, c, acc ? $urandom_range(LONG_MIN, 2 * LONG_MIN) : $urandom_range(1, SHORT_MAX), acc);
         cycles($urandom_range(GAP, GAP + 20));
      end

      // Reset while in PRESS_DB: nothing may be reported afterwards.
      reset = 1'b1;
      cycles(2);
      hist_new = 4'h0;
      hist_old = 4'h0;
      reset = 1'b0;
      pressed[0][0] = 1'b1;
      cycles(6);
      reset = 1'b1;
      cycles(1);
      check("abort_cols", {28'b0, cols}, 32'hE);
      check("abort_key_valid", {31'b0, key_valid}, 32'd0);
      check("abort_digit_new", {28'b0, digit_new}, 32'd0);
      check("abort_digit_old", {28'b0, digit_old}, 32'd0);
      pressed[0][0] = 1'b0;
      cycles(3);
      reset = 1'b0;
      cycles(GAP + 10);

      check("no_missing_pulses", exp_q.size(), 32'd0);
      check("pulse_count", n_pulses, n_pushed);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
